dm_responder: RTL and testbench
===============================

Name: dm_responder

Overview:
- Data-memory responder: the memory end of the load/store interface the processor core initiates.
- Accepts one word-addressed read or write request at a time over a valid/ready handshake.
- Returns a response after a fixed latency and holds it until the core takes it.
- Owns the data RAM, including a zero-clear sweep after reset. Sits between the core's MEM stage and the backing storage.

Parameters:
DEPTH, 3072, number of 32-bit words in the RAM.
BASE, 32'h0000_0000, byte address of word 0.
LATENCY, 2, cycles from the accept edge to rsp_valid high; legal range 1..15.

Ports:
clk  input  1  clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset.
req_valid  input  1  request present.
req_ready  output  1  responder can accept; high only in IDLE.
req_we  input  1  1 = write, 0 = read.
req_addr  input  32  byte address.
req_wdata  input  32  write data.
req_be  input  4  byte enables; bit i covers bits [8i+7:8i].
req_pc  input  32  PC of the issuing instruction; used only for the trace.
rsp_valid  output  1  response present.
rsp_ready  input  1  initiator takes the response.
rsp_rdata  output  32  read data; merged new word for writes; 0 on error.
rsp_err  output  1  request rejected.

Behaviour:
- Reset (reset low, asynchronous):
  - Go to CLEAR with clear index 0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Any in-flight request or response is dropped.
- States: CLEAR, IDLE, BUSY, RESP.
- CLEAR:
  - Writes 0 to word[idx] each cycle; idx increments.
  - After word DEPTH-1 is written, go to IDLE.
  - Takes exactly DEPTH cycles after reset deasserts. req_ready=0 throughout.
- IDLE:
  - req_ready=1. Accept edge = rising edge with req_valid && req_ready.
  - On accept: go to RESP if LATENCY==1, otherwise BUSY with counter = LATENCY-1.
- Address check at accept:
  - index = (req_addr - BASE) >> 2.
  - Error if req_addr[1:0] != 0, req_addr < BASE, or index >= DEPTH.
- Write at accept, no error:
  - Bytes with req_be=1 are replaced; other bytes are kept.
  - Commits on the accept edge.
  - Captured rdata = the merged word.
  - req_be == 0 is legal: no change, rdata = the current word.
- Read at accept, no error:
  - rdata = word[index] as of before the accept edge. req_be is ignored.
- Error at accept: no RAM change; captured rdata=0, err=1.
- BUSY:
  - Counter decrements each cycle; go to RESP when it reaches 1 → 0.
  - rsp_valid rises exactly LATENCY cycles after the accept edge.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err held stable.
  - On rsp_valid && rsp_ready: go to IDLE, rsp_valid=0, rsp_rdata/rsp_err keep their last value.
  - Back-pressure: rsp_ready may stay low indefinitely. No new request is accepted until the response is taken.
- Throughput: at most one request per LATENCY+1 cycles. At most one outstanding request.
- req_valid while not in IDLE is ignored; the initiator must hold the request.
- Address arithmetic is unsigned 32-bit; wrap-around below BASE is caught by the req_addr < BASE check.

Optional Feature:
- DM_TRACE_EN defined: on every committed, non-error write, print at the accept edge:
  "<$time>@<req_pc hex 8>: *<req_addr hex 8> <= <merged word hex 8>".
  - Nothing is printed for reads, errors or CLEAR writes.
- Undefined: no simulation output. Functional behaviour is identical.

Test Plan:
1. Release reset, req_valid=1 (read 0x0) → req_ready low for 3072 cycles; then accept; rsp_valid 2 cycles later; rsp_rdata=0, rsp_err=0.
2. Write 0x10 = 0xDEADBEEF with be=4'hF, then read 0x10 → both responses err=0; read rsp_rdata=0xDEADBEEF; each rsp_valid exactly 2 cycles after its accept edge.
3. Write 0x10 = 0x0000_1234 with be=4'b0011 → write rsp_rdata=0xDEAD1234; a later read of 0x10 = 0xDEAD1234.
4. Write 0x12 (misaligned) and read 0x3000 (index 3072) → both rsp_err=1, rsp_rdata=0; read 0x10 still 0xDEAD1234.
5. Read 0x10 with rsp_ready low for 5 cycles → rsp_valid/rsp_rdata stable the whole time; req_ready=0; a new req_valid is not accepted until the cycle after rsp_ready=1.
6. Assert reset during BUSY of a write → rsp_valid=0 immediately (asynchronous); after the CLEAR sweep, read 0x10 = 0. With DM_TRACE_EN, scenario 2's write prints "…@<pc>: *00000010 <= deadbeef".

Source files
------------

// File: rtl/dm_responder.sv
// dm_responder: data-memory responder for the core's load/store port.
// One word-addressed request at a time over valid/ready, fixed-latency
// response held until taken, zero-clear sweep of the RAM after reset.
// Optional: define DM_TRACE_EN to print every committed, non-error write.
module dm_responder #(
  parameter int unsigned DEPTH   = 3072,
  parameter logic [31:0] BASE    = 32'h0000_0000,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW = 4;

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_BUSY, S_RESP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [31:0]       r_mem [DEPTH];
  logic [IDXW-1:0]   r_clr_idx;
  logic [CNTW-1:0]   r_cnt;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;

  logic [29:0]       w_word;
  logic [IDXW-1:0]   w_idx;
  logic              w_err;
  logic [31:0]       w_cur;
  logic [31:0]       w_merged;
  logic [31:0]       w_cap_rdata;
  logic              w_accept;
  logic              w_take;
  logic              w_mem_we;
  logic [IDXW-1:0]   w_mem_idx;
  logic [31:0]       w_mem_wdata;

  // Address decode: unsigned offset from BASE; wrap below BASE is caught explicitly
  assign w_word   = 30'((req_addr - BASE) >> 2);
  assign w_idx    = w_word[IDXW-1:0];
  assign w_err    = (req_addr[1:0] != 2'b00) || (req_addr < BASE) ||
                    (w_word >= 30'(DEPTH));
  assign w_cur    = w_err ? 32'h0 : r_mem[w_idx];
  assign w_accept = r_req_ready && req_valid;
  assign w_take   = r_rsp_valid && rsp_ready;

  // Byte-enable merge of write data into the current word
  always_comb begin
    w_merged = w_cur;
    for (int i = 0; i < 4; i++) begin
      if (req_be[i]) w_merged[8*i +: 8] = req_wdata[8*i +: 8];
    end
  end

  assign w_cap_rdata = w_err ? 32'h0 : (req_we ? w_merged : w_cur);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_CLEAR;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_CLEAR: if (r_clr_idx == IDXW'(DEPTH - 1)) w_next = S_IDLE;
      S_IDLE:  if (w_accept) w_next = (LATENCY == 1) ? S_RESP : S_BUSY;
      S_BUSY:  if (r_cnt == CNTW'(1)) w_next = S_RESP;
      S_RESP:  if (w_take) w_next = S_IDLE;
      default: w_next = S_CLEAR;
    endcase
  end

  // RAM write-port control: clear sweep or committed write
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_idx   = w_idx;
    w_mem_wdata = w_merged;
    case (r_state)
      S_CLEAR: begin
        w_mem_we    = 1'b1;
        w_mem_idx   = r_clr_idx;
        w_mem_wdata = 32'h0;
      end
      S_IDLE:  w_mem_we = w_accept && req_we && !w_err;
      default: w_mem_we = 1'b0;
    endcase
  end

  // Sweep index, latency counter and registered response/handshake outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clr_idx   <= '0;
      r_cnt       <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (r_state == S_CLEAR) r_clr_idx <= r_clr_idx + IDXW'(1);
      if (w_accept)                r_cnt <= CNTW'(LATENCY - 1);
      else if (r_state == S_BUSY)  r_cnt <= r_cnt - CNTW'(1);
      r_req_ready <= (w_next == S_IDLE);
      r_rsp_valid <= (r_state == S_RESP) && !w_take;
      if (w_accept) begin
        r_rsp_rdata <= w_cap_rdata;
        r_rsp_err   <= w_err;
      end
    end
  end

  // Data RAM
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_idx] <= w_mem_wdata;
  end

`ifdef DM_TRACE_EN
  // Store trace at the accept edge of committed writes
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_accept && req_we && !w_err)
      $display("%0t@%08h: *%08h <= %08h", $time, req_pc, req_addr, w_merged);
  end
`else
  logic w_unused_pc;
  assign w_unused_pc = ^req_pc;
`endif

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder (DEPTH=3072, BASE=0, LATENCY=2).
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_be = 4'h0;
  logic [31:0] req_pc = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_vec = 0;
  int n_err = 0;

  dm_responder dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .req_pc    (req_pc),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Count edges until req_ready rises after reset release
  task automatic wait_clear(input string tag);
    int cnt;
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!req_ready && cnt < 4000);
    chk({tag, "_clear_cycles"}, 32'(cnt), 32'd3072);
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] pc);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    req_pc    = pc;
  endtask

  // Full transaction: accept, latency, payload, take
  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      input logic [31:0] exp_rd, input logic exp_err);
    int n;
    int lat;
    issue(we, addr, wdata, be, 32'h0000_1000 + addr);
    n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({tag, "_busy"}, 32'(req_ready), 32'd0);
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd2);
    chk({tag, "_rdata"}, rsp_rdata, exp_rd);
    chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "_taken"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int n;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);

    // 1: request held through the clear sweep
    issue(1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    reset = 1'b1;
    wait_clear("t1");
    xact("t1_rd0", 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0);

    // 2: full-word write then read
    xact("t2_wr", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 1'b0);
    xact("t2_rd", 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);

    // 3: partial write merges low half
    xact("t3_wr", 1'b1, 32'h10, 32'h0000_1234, 4'b0011, 32'hDEAD1234, 1'b0);
    xact("t3_rd", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD1234, 1'b0);
    xact("t3_be0", 1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, 32'hDEAD1234, 1'b0);

    // 4: error cases and range boundary
    xact("t4_mis", 1'b1, 32'h12, 32'h1111_1111, 4'hF, 32'h0, 1'b1);
    xact("t4_oor", 1'b0, 32'h3000, 32'h0, 4'h0, 32'h0, 1'b1);
    xact("t4_last", 1'b0, 32'h2FFC, 32'h0, 4'h0, 32'h0, 1'b0);
    xact("t4_rd", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD1234, 1'b0);

    // 5: back-pressure with a competing request held
    issue(1'b0, 32'h10, 32'h0, 4'h0, 32'h2000);
    n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    issue(1'b0, 32'h0, 32'h0, 4'h0, 32'h2004);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_valid", 32'(rsp_valid), 32'd1);
      chk("t5_hold_rdata", rsp_rdata, 32'hDEAD1234);
      chk("t5_hold_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("t5_taken", 32'(rsp_valid), 32'd0);
    chk("t5_idle", 32'(req_ready), 32'd1);
    xact("t5_next", 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0);

    // 6: asynchronous reset during BUSY of a write
    issue(1'b1, 32'h10, 32'h55AA_55AA, 4'hF, 32'h3000);
    n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(rsp_valid), 32'd0);
    chk("t6_rst_ready", 32'(req_ready), 32'd0);
    chk("t6_rst_rdata", rsp_rdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    wait_clear("t6");
    xact("t6_rd", 1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
